// File: rtl/pps_discipline_if.sv
// PPS discipline bundle: raw PPS input plus the disciplined tick, period and status flags.
//   pps_in   : raw GPS PPS, asynchronous to the block clock
//   tick     : one-cycle seconds pulse
//   period   : last accepted PPS period in cycles
//   locked   : tick is phase-locked to PPS
//   holdover : tick is free-running from the last accepted period
//   pps_err  : one-cycle pulse for an out-of-window PPS edge
interface pps_discipline_if #(
    parameter int unsigned WIDTH = 28
);
    logic             pps_in;
    logic             tick;
    logic [WIDTH-1:0] period;
    logic             locked;
    logic             holdover;
    logic             pps_err;

    // Time source side (GPS receiver / consumer of the seconds tick)
    modport master (
        output pps_in,
        input  tick,
        input  period,
        input  locked,
        input  holdover,
        input  pps_err
    );

    // Discipline block side
    modport slave (
        input  pps_in,
        output tick,
        output period,
        output locked,
        output holdover,
        output pps_err
    );
endinterface

// File: rtl/pps_discipline.sv
// Disciplines the local 1 Hz tick to GPS PPS.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : pps_discipline_if.slave (pps_in in; tick, period, locked, holdover, pps_err out)
// The PPS input is double-synchronised and edge-detected; every action taken on a
// PPS edge is registered, so outputs move two clocks after the edge is first sampled.
module pps_discipline #(
    parameter int unsigned WIDTH        = 28,
    parameter int unsigned NOMINAL      = 50_000_000,
    parameter int unsigned TOL          = 5000,
    parameter int unsigned HOLDOVER_MAX = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    pps_discipline_if.slave        bus
);

    localparam int unsigned MISS_W = (HOLDOVER_MAX < 2) ? 1 : $clog2(HOLDOVER_MAX + 1);

    localparam logic [WIDTH-1:0]  NOM_W     = WIDTH'(NOMINAL);
    localparam logic [WIDTH-1:0]  WIN_LO    = WIDTH'(NOMINAL - TOL);
    localparam logic [WIDTH-1:0]  WIN_HI    = WIDTH'(NOMINAL + TOL);
    localparam logic [WIDTH-1:0]  ACQ_LIMIT = WIDTH'(NOMINAL + TOL + 1);
    localparam logic [WIDTH:0]    HOLD_ADD  = (WIDTH+1)'(TOL + 1);
    localparam logic [MISS_W-1:0] MISS_MAX  = MISS_W'(HOLDOVER_MAX);

    typedef enum logic [1:0] {
        ST_UNLOCKED,
        ST_ACQUIRE,
        ST_LOCKED,
        ST_HOLDOVER
    } state_e;

    state_e            state_q,    state_d;
    logic [WIDTH-1:0]  pcnt_q,     pcnt_d;
    logic [WIDTH-1:0]  div_q,      div_d;
    logic [WIDTH-1:0]  period_q,   period_d;
    logic [MISS_W-1:0] miss_q,     miss_d;
    logic              tick_q,     tick_d;
    logic              pps_err_q,  pps_err_d;
    logic              locked_q,   locked_d;
    logic              holdover_q, holdover_d;

    logic [2:0]        sync_q;
    logic              pps_edge_c;
    logic              meas_ok_c;
    logic              div_tick_c;
    logic              hold_timeout_c;
    logic [WIDTH-1:0]  div_range_c;
    logic [MISS_W-1:0] miss_inc_c;

    // Two synchroniser flops plus one history flop for rising-edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], bus.pps_in};
        end
    end

    assign pps_edge_c = sync_q[1] & ~sync_q[2];

    // Measurement is the running count at the edge; window check is inclusive
    assign meas_ok_c      = (pcnt_q >= WIN_LO) && (pcnt_q <= WIN_HI);
    assign hold_timeout_c = ({1'b0, pcnt_q} == ({1'b0, period_q} + HOLD_ADD));

    // Divider range follows the held period only in holdover; >= keeps it safe
    // when the range shrinks while the divider is already past the new end
    assign div_range_c = (state_q == ST_HOLDOVER) ? period_q : NOM_W;
    assign div_tick_c  = (div_q >= (div_range_c - WIDTH'(1)));
    assign miss_inc_c  = miss_q + MISS_W'(1);

    // State and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_UNLOCKED;
            pcnt_q     <= '0;
            div_q      <= '0;
            period_q   <= NOM_W;
            miss_q     <= '0;
            tick_q     <= 1'b0;
            pps_err_q  <= 1'b0;
            locked_q   <= 1'b0;
            holdover_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pcnt_q     <= pcnt_d;
            div_q      <= div_d;
            period_q   <= period_d;
            miss_q     <= miss_d;
            tick_q     <= tick_d;
            pps_err_q  <= pps_err_d;
            locked_q   <= locked_d;
            holdover_q <= holdover_d;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d   = state_q;
        period_d  = period_q;
        miss_d    = miss_q;
        tick_d    = 1'b0;
        pps_err_d = 1'b0;

        // Period counter restarts at 1 on each edge so edges N apart measure N
        if (pps_edge_c) begin
            pcnt_d = WIDTH'(1);
        end else if (pcnt_q != '1) begin
            pcnt_d = pcnt_q + WIDTH'(1);
        end else begin
            pcnt_d = pcnt_q;
        end

        div_d = div_tick_c ? '0 : (div_q + WIDTH'(1));

        unique case (state_q)
            ST_UNLOCKED: begin
                tick_d = div_tick_c;
                if (pps_edge_c) begin
                    state_d = ST_ACQUIRE;
                end
            end

            ST_ACQUIRE: begin
                tick_d = div_tick_c;
                if (pps_edge_c) begin
                    if (meas_ok_c) begin
                        period_d = pcnt_q;
                        tick_d   = 1'b1;
                        div_d    = '0;
                        state_d  = ST_LOCKED;
                    end else begin
                        pps_err_d = 1'b1;
                    end
                end else if (pcnt_q == ACQ_LIMIT) begin
                    state_d = ST_UNLOCKED;
                end
            end

            ST_LOCKED: begin
                div_d = '0;
                if (pps_edge_c) begin
                    if (meas_ok_c) begin
                        period_d = pcnt_q;
                        tick_d   = 1'b1;
                    end else begin
                        pps_err_d = 1'b1;
                        state_d   = ST_ACQUIRE;
                    end
                end else if (hold_timeout_c) begin
                    // Missing edge: substitute a tick now and free-run from here
                    tick_d  = 1'b1;
                    miss_d  = MISS_W'(1);
                    state_d = ST_HOLDOVER;
                end
            end

            ST_HOLDOVER: begin
                tick_d = div_tick_c;
                if (pps_edge_c) begin
                    state_d = ST_ACQUIRE;
                end else if (div_tick_c) begin
                    miss_d = miss_inc_c;
                    if (miss_inc_c == MISS_MAX) begin
                        state_d = ST_UNLOCKED;
                    end
                end
            end

            default: begin
                state_d = ST_UNLOCKED;
            end
        endcase

        locked_d   = (state_d == ST_LOCKED);
        holdover_d = (state_d == ST_HOLDOVER);
    end

    assign bus.tick     = tick_q;
    assign bus.period   = period_q;
    assign bus.locked   = locked_q;
    assign bus.holdover = holdover_q;
    assign bus.pps_err  = pps_err_q;

endmodule

// File: tb/tb_pps_discipline.sv
// Directed bench for pps_discipline with NOMINAL=100, TOL=5, HOLDOVER_MAX=3, WIDTH=28.
// Inputs change and outputs are sampled 1 ns after the rising clock edge.
module tb_pps_discipline;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_mis;
    int   n;

    pps_discipline_if #(.WIDTH(28)) bus();

    pps_discipline #(
        .WIDTH        (28),
        .NOMINAL      (100),
        .TOL          (5),
        .HOLDOVER_MAX (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 ns
    task automatic tk(input int cyc);
        repeat (cyc) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Raise PPS so it is sampled at the next edge k; return just after edge k+2
    task automatic pulse();
        bus.pps_in = 1'b1;
        tk(3);
        bus.pps_in = 1'b0;
    endtask

    // Next PPS sample 'gap' cycles after the previous one; 'used' cycles already spent since pulse()
    task automatic gap_pulse(input int gap, input int used);
        tk(gap - 3 - used);
        pulse();
    endtask

    // Count edges until tick is seen; -1 if the bound expires
    task automatic wait_tick(input int max_cyc, output int cnt);
        cnt = 0;
        do begin
            tk(1);
            cnt++;
        end while (bus.tick !== 1'b1 && cnt < max_cyc);
        if (bus.tick !== 1'b1) cnt = -1;
    endtask

    initial begin
        n_cmp      = 0;
        n_mis      = 0;
        reset      = 1'b0;
        bus.pps_in = 1'b0;

        // Reset values
        tk(3);
        chk("rst_tick",     32'(bus.tick),     32'd0);
        chk("rst_locked",   32'(bus.locked),   32'd0);
        chk("rst_holdover", 32'(bus.holdover), 32'd0);
        chk("rst_pps_err",  32'(bus.pps_err),  32'd0);
        chk("rst_period",   32'(bus.period),   32'd100);
        reset = 1'b1;

        // Free-run: tick every NOMINAL cycles
        wait_tick(250, n);
        chk("free_first_tick", 32'(n), 32'd100);
        wait_tick(250, n);
        chk("free_spacing", 32'(n), 32'd100);
        tk(1);
        chk("free_tick_width", 32'(bus.tick),     32'd0);
        chk("free_locked",     32'(bus.locked),   32'd0);
        chk("free_holdover",   32'(bus.holdover), 32'd0);
        chk("free_period",     32'(bus.period),   32'd100);

        // Acquire and lock at 102
        pulse();
        chk("acq_tick",    32'(bus.tick),    32'd0);
        chk("acq_pps_err", 32'(bus.pps_err), 32'd0);
        chk("acq_locked",  32'(bus.locked),  32'd0);
        gap_pulse(102, 0);
        chk("lock_tick",     32'(bus.tick),     32'd1);
        chk("lock_locked",   32'(bus.locked),   32'd1);
        chk("lock_period",   32'(bus.period),   32'd102);
        chk("lock_holdover", 32'(bus.holdover), 32'd0);
        chk("lock_pps_err",  32'(bus.pps_err),  32'd0);
        tk(1);
        chk("lock_tick_width", 32'(bus.tick), 32'd0);
        gap_pulse(102, 1);
        chk("lock2_tick",   32'(bus.tick),   32'd1);
        chk("lock2_period", 32'(bus.period), 32'd102);

        // Out-of-window edge while locked
        gap_pulse(100, 0);
        chk("lock100_tick",   32'(bus.tick),   32'd1);
        chk("lock100_period", 32'(bus.period), 32'd100);
        gap_pulse(90, 0);
        chk("oow_pps_err", 32'(bus.pps_err), 32'd1);
        chk("oow_tick",    32'(bus.tick),    32'd0);
        chk("oow_locked",  32'(bus.locked),  32'd0);
        chk("oow_period",  32'(bus.period),  32'd100);
        tk(1);
        chk("oow_err_width", 32'(bus.pps_err), 32'd0);
        // Relock edge coincides with a divider tick: one merged pulse
        gap_pulse(100, 1);
        chk("relock_tick",   32'(bus.tick),   32'd1);
        chk("relock_locked", 32'(bus.locked), 32'd1);
        chk("relock_period", 32'(bus.period), 32'd100);
        tk(1);
        chk("relock_merge_width", 32'(bus.tick), 32'd0);
        gap_pulse(100, 1);
        chk("relock2_tick", 32'(bus.tick), 32'd1);

        // Lost PPS: lock at 102, then holdover
        gap_pulse(102, 0);
        chk("pre_hold_period", 32'(bus.period), 32'd102);
        wait_tick(250, n);
        chk("hold_entry_delay", 32'(n),            32'd108);
        chk("hold_entry_flag",  32'(bus.holdover), 32'd1);
        chk("hold_entry_lock",  32'(bus.locked),   32'd0);
        wait_tick(250, n);
        chk("hold_tick2", 32'(n),            32'd102);
        chk("hold_flag2", 32'(bus.holdover), 32'd1);
        wait_tick(250, n);
        chk("hold_tick3",      32'(n),            32'd102);
        chk("hold_exit_flag",  32'(bus.holdover), 32'd0);
        chk("hold_exit_lock",  32'(bus.locked),   32'd0);
        wait_tick(250, n);
        chk("unlocked_spacing", 32'(n),          32'd100);
        chk("unlocked_period",  32'(bus.period), 32'd102);

        // Recovery from holdover with PPS at 99
        pulse();
        gap_pulse(102, 0);
        chk("rec_lock", 32'(bus.locked), 32'd1);
        wait_tick(250, n);
        chk("rec_hold_delay", 32'(n),            32'd108);
        chk("rec_hold_flag",  32'(bus.holdover), 32'd1);
        pulse();
        chk("rec_acq_holdover", 32'(bus.holdover), 32'd0);
        chk("rec_acq_locked",   32'(bus.locked),   32'd0);
        chk("rec_acq_tick",     32'(bus.tick),     32'd0);
        chk("rec_acq_pps_err",  32'(bus.pps_err),  32'd0);
        chk("rec_acq_period",   32'(bus.period),   32'd102);
        gap_pulse(99, 0);
        chk("rec_lock_tick",   32'(bus.tick),   32'd1);
        chk("rec_lock_locked", 32'(bus.locked), 32'd1);
        chk("rec_lock_period", 32'(bus.period), 32'd99);
        gap_pulse(99, 0);
        chk("rec_lock2_tick", 32'(bus.tick), 32'd1);

        // Asynchronous reset mid-period while locked
        tk(40);
        chk("pre_rst_locked", 32'(bus.locked), 32'd1);
        reset = 1'b0;
        #1;
        chk("arst_locked",   32'(bus.locked),   32'd0);
        chk("arst_period",   32'(bus.period),   32'd100);
        chk("arst_tick",     32'(bus.tick),     32'd0);
        chk("arst_holdover", 32'(bus.holdover), 32'd0);
        chk("arst_pps_err",  32'(bus.pps_err),  32'd0);
        tk(3);
        chk("arst_hold_locked", 32'(bus.locked), 32'd0);
        reset = 1'b1;
        wait_tick(250, n);
        chk("arst_free_tick", 32'(n),          32'd100);
        chk("arst_free_lock", 32'(bus.locked), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    // Global watchdog
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
